// File: rtl/alu_issue_stage.sv
// +--------------------------------------------------------------------------+
// | alu_issue_stage: RV32I decode into ALU op/operands, ID/EX skid register  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package type_enums;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;
endpackage

module alu_issue_stage
  import type_enums::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output alu_op_t          alu_op,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  output logic [4:0]       rd,
  output logic             illegal
);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_BUSY  = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;

  typedef struct packed {
    alu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       rd;
    logic             ill;
  } entry_t;

  function automatic alu_op_t f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]       w_opcode, w_f7;
  logic [2:0]       w_f3;
  logic             w_f7_zero, w_f7_alt, w_shift, w_ill;
  logic [WIDTH-1:0] w_imm_i, w_imm_s, w_imm_u, w_shamt;
  entry_t           w_dec;

  assign w_opcode  = instr[6:0];
  assign w_f3      = instr[14:12];
  assign w_f7      = instr[31:25];
  assign w_f7_zero = (w_f7 == 7'b0000000);
  assign w_f7_alt  = (w_f7 == 7'b0100000);
  assign w_shift   = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_imm_i   = WIDTH'($signed(instr[31:20]));
  assign w_imm_s   = WIDTH'($signed({instr[31:25], instr[11:7]}));
  assign w_imm_u   = WIDTH'($signed({instr[31:12], 12'b0}));
  assign w_shamt   = WIDTH'(instr[24:20]);

  always_comb begin
    w_dec    = '0;
    w_dec.op = ALU_ADD;
    w_ill    = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        w_dec.a  = rs1_data;
        w_dec.b  = rs2_data;
        w_dec.rd = instr[11:7];
        w_dec.op = f3_op(w_f3, w_f7_alt);
        w_ill    = !(w_f7_zero || (w_f7_alt && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      7'b0010011: begin
        w_dec.a  = rs1_data;
        w_dec.b  = w_shift ? w_shamt : w_imm_i;
        w_dec.rd = instr[11:7];
        // Only SRAI may set bit 30; ADDI never becomes SUB.
        w_dec.op = f3_op(w_f3, w_shift && instr[30]);
        w_ill    = w_shift && !(w_f7_zero || (w_f7_alt && w_f3 == 3'b101));
      end
      7'b0110111: begin
        w_dec.b  = w_imm_u;
        w_dec.rd = instr[11:7];
      end
      7'b0010111: begin
        w_dec.a  = pc;
        w_dec.b  = w_imm_u;
        w_dec.rd = instr[11:7];
      end
      7'b1101111, 7'b1100111: begin
        w_dec.a  = pc;
        w_dec.b  = WIDTH'(4);
        w_dec.rd = instr[11:7];
      end
      7'b0000011: begin
        w_dec.a  = rs1_data;
        w_dec.b  = w_imm_i;
        w_dec.rd = instr[11:7];
      end
      7'b0100011: begin
        w_dec.a = rs1_data;
        w_dec.b = w_imm_s;
      end
      7'b1100011: begin
        w_dec.a = rs1_data;
        w_dec.b = rs2_data;
        case (w_f3[2:1])
          2'b00:   w_dec.op = ALU_SUB;
          2'b10:   w_dec.op = ALU_SLT;
          2'b11:   w_dec.op = ALU_SLTU;
          default: w_ill    = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_dec     = '0;
      w_dec.op  = ALU_ADD;
      w_dec.ill = 1'b1;
    end
  end

  logic [1:0] r_state, w_next_state;
  logic       r_in_ready;
  entry_t     r_m, r_s;
  logic       w_accept, w_pop, w_load_m, w_load_s, w_m_from_s;

  assign w_accept = in_valid && r_in_ready;
  assign w_pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_EMPTY;
      r_in_ready <= 1'b1;
      r_m        <= '0;
      r_s        <= '0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != c_FULL);
      if (w_load_m)   r_m <= w_dec;
      if (w_m_from_s) r_m <= r_s;
      if (w_load_s)   r_s <= w_dec;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = c_EMPTY;
    end else begin
      case (r_state)
        c_EMPTY: if (w_accept) w_next_state = c_BUSY;
        c_BUSY: begin
          if (w_accept && !w_pop)      w_next_state = c_FULL;
          else if (w_pop && !w_accept) w_next_state = c_EMPTY;
        end
        c_FULL:  if (w_pop) w_next_state = c_BUSY;
        default: w_next_state = c_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid  = (r_state != c_EMPTY);
    w_load_m   = !flush && w_accept && (r_state == c_EMPTY || (r_state == c_BUSY && w_pop));
    w_load_s   = !flush && w_accept && r_state == c_BUSY && !w_pop;
    w_m_from_s = !flush && r_state == c_FULL && w_pop;
  end

  assign in_ready = r_in_ready;
  assign alu_op   = r_m.op;
  assign opA      = r_m.a;
  assign opB      = r_m.b;
  assign rd       = r_m.rd;
  assign illegal  = r_m.ill;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: decode vectors, handshake corner sequences, random FIFO model.
`default_nettype none

module tb_alu_issue_stage;
  import type_enums::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instr, pc, rs1_data, rs2_data, opA, opB;
  logic [4:0]  rd;
  alu_op_t     alu_op;

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .opA(opA), .opB(opB), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_op_t     op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins, pc, r1, r2;
    exp_t        e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic chk_entry(input string name, input exp_t e);
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
    chk({name, ".op"}, 32'(alu_op), 32'(e.op));
    chk({name, ".opA"}, opA, e.a);
    chk({name, ".opB"}, opB, e.b);
    chk({name, ".rd"}, 32'(rd), 32'(e.rd));
    chk({name, ".illegal"}, 32'(illegal), 32'(e.ill));
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".valid"}, 32'(out_valid), 32'd0);
    chk({name, ".ready"}, 32'(in_ready), 32'd1);
    chk({name, ".op"}, 32'(alu_op), 32'(ALU_ADD));
    chk({name, ".opA"}, opA, 32'd0);
    chk({name, ".opB"}, opB, 32'd0);
    chk({name, ".rd"}, 32'(rd), 32'd0);
    chk({name, ".illegal"}, 32'(illegal), 32'd0);
  endtask

  // Reference decoder written from the ISA rules with plain arithmetic.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    int          f3, f7, opc;
    logic [31:0] immi, imms, immu, sh;
    alu_op_t     base[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic        bad = 1'b0;
    opc  = int'(ins & 32'h7F);
    f3   = int'((ins >> 12) & 32'h7);
    f7   = int'(ins >> 25);
    immi = 32'($signed(ins) >>> 20);
    imms = (immi & ~32'h1F) | ((ins >> 7) & 32'h1F);
    immu = ins & 32'hFFFFF000;
    sh   = (ins >> 20) & 32'h1F;
    e    = '{ALU_ADD, 32'd0, 32'd0, 5'((ins >> 7) & 32'h1F), 1'b0};
    case (opc)
      'h33: begin
        e.a = r1; e.b = r2; e.op = base[f3];
        if (f7 == 'h20 && f3 == 0) e.op = ALU_SUB;
        else if (f7 == 'h20 && f3 == 5) e.op = ALU_SRA;
        else if (f7 != 0) bad = 1'b1;
      end
      'h13: begin
        e.a = r1; e.op = base[f3];
        if (f3 == 1 || f3 == 5) begin
          e.b = sh;
          if (f3 == 5 && f7 == 'h20) e.op = ALU_SRA;
          else if (f7 != 0) bad = 1'b1;
        end else e.b = immi;
      end
      'h37: e.b = immu;
      'h17: begin e.a = p; e.b = immu; end
      'h6F, 'h67: begin e.a = p; e.b = 4; end
      'h03: begin e.a = r1; e.b = immi; end
      'h23: begin e.a = r1; e.b = imms; e.rd = 0; end
      'h63: begin
        e.a = r1; e.b = r2; e.rd = 0;
        if (f3 <= 1) e.op = ALU_SUB;
        else if (f3 == 4 || f3 == 5) e.op = ALU_SLT;
        else if (f3 >= 6) e.op = ALU_SLTU;
        else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) e = '{ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b1};
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins);
    in_valid = v;
    instr    = ins;
  endtask

  vec_t vt[17];
  exp_t q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Expected values hand-derived from the RV32I encodings.
    vt[0]  = '{32'hFFB00093, 32'h0, 32'h0, 32'h0, '{ALU_ADD, 32'h0, 32'hFFFFFFFB, 5'd1, 1'b0}};
    vt[1]  = '{32'h4030D093, 32'h0, 32'h80000000, 32'h0, '{ALU_SRA, 32'h80000000, 32'h3, 5'd1, 1'b0}};
    vt[2]  = '{32'h40000033, 32'h0, 32'h11, 32'h22, '{ALU_SUB, 32'h11, 32'h22, 5'd0, 1'b0}};
    vt[3]  = '{32'h0020E463, 32'h0, 32'h5, 32'h6, '{ALU_SLTU, 32'h5, 32'h6, 5'd0, 1'b0}};
    vt[4]  = '{32'h123452B7, 32'h0, 32'hAA, 32'h0, '{ALU_ADD, 32'h0, 32'h12345000, 5'd5, 1'b0}};
    vt[5]  = '{32'hFFFFFFFF, 32'h40, 32'h1, 32'h2, '{ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b1}};
    vt[6]  = '{32'h80000397, 32'h1000, 32'h0, 32'h0, '{ALU_ADD, 32'h1000, 32'h80000000, 5'd7, 1'b0}};
    vt[7]  = '{32'h008000EF, 32'h2000, 32'h0, 32'h0, '{ALU_ADD, 32'h2000, 32'h4, 5'd1, 1'b0}};
    vt[8]  = '{32'hFE20AE23, 32'h0, 32'h300, 32'h9, '{ALU_ADD, 32'h300, 32'hFFFFFFFC, 5'd0, 1'b0}};
    vt[9]  = '{32'h00208463, 32'h0, 32'h7, 32'h8, '{ALU_SUB, 32'h7, 32'h8, 5'd0, 1'b0}};
    vt[10] = '{32'h0020D463, 32'h0, 32'h7, 32'h8, '{ALU_SLT, 32'h7, 32'h8, 5'd0, 1'b0}};
    vt[11] = '{32'h0020A463, 32'h0, 32'h7, 32'h8, '{ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b1}};
    vt[12] = '{32'h40109093, 32'h0, 32'h7, 32'h8, '{ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b1}};
    vt[13] = '{32'h022081B3, 32'h0, 32'h7, 32'h8, '{ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b1}};
    vt[14] = '{32'h7FF0C193, 32'h0, 32'h7, 32'h8, '{ALU_XOR, 32'h7, 32'h7FF, 5'd3, 1'b0}};
    vt[15] = '{32'h0020B1B3, 32'h0, 32'h7, 32'h8, '{ALU_SLTU, 32'h7, 32'h8, 5'd3, 1'b0}};
    vt[16] = '{32'h0080A203, 32'h0, 32'h10, 32'h8, '{ALU_ADD, 32'h10, 32'h8, 5'd4, 1'b0}};

    for (int i = 0; i < 17; i++) begin
      pc = vt[i].pc; rs1_data = vt[i].r1; rs2_data = vt[i].r2;
      drive(1'b1, vt[i].ins);
      @(negedge clk);
      drive(1'b0, 32'h0);
      chk_entry($sformatf("vec%0d", i), vt[i].e);
    end
    @(negedge clk);
    chk("vec_drain.valid", 32'(out_valid), 32'd0);

    // Back-pressure: A,B,C pushed with out_ready low.
    rs1_data = 32'h0; out_ready = 1'b0;
    drive(1'b1, 32'h00100093);
    @(negedge clk);
    chk("bp.ready_after_A", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h00200113);
    @(negedge clk);
    chk("bp.ready_after_B", 32'(in_ready), 32'd0);
    chk_entry("bp.A_head", '{ALU_ADD, 32'h0, 32'h1, 5'd1, 1'b0});
    drive(1'b1, 32'h00300193);
    @(negedge clk);
    chk("bp.C_held_ready", 32'(in_ready), 32'd0);
    chk_entry("bp.A_stable", '{ALU_ADD, 32'h0, 32'h1, 5'd1, 1'b0});
    out_ready = 1'b1;
    @(negedge clk);
    chk_entry("bp.B_out", '{ALU_ADD, 32'h0, 32'h2, 5'd2, 1'b0});
    chk("bp.ready_after_pop", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0);
    chk_entry("bp.C_out", '{ALU_ADD, 32'h0, 32'h3, 5'd3, 1'b0});
    @(negedge clk);
    chk("bp.drained", 32'(out_valid), 32'd0);

    // Flush while BUSY with a same-cycle accept.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093);
    @(negedge clk);
    flush = 1'b1; drive(1'b1, 32'h00200113);
    @(negedge clk);
    flush = 1'b0; drive(1'b0, 32'h0);
    chk("flush_busy.valid", 32'(out_valid), 32'd0);
    chk("flush_busy.ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("flush_busy.no_capture", 32'(out_valid), 32'd0);

    // Flush while FULL.
    drive(1'b1, 32'h00100093);
    @(negedge clk);
    drive(1'b1, 32'h00200113);
    @(negedge clk);
    chk("flush_full.is_full", 32'(in_ready), 32'd0);
    flush = 1'b1; drive(1'b1, 32'h00300193);
    @(negedge clk);
    flush = 1'b0; drive(1'b0, 32'h0);
    chk("flush_full.valid", 32'(out_valid), 32'd0);
    chk("flush_full.ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("flush_full.no_capture", 32'(out_valid), 32'd0);

    // Randomised traffic against the queue model.
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic acc, pp;
      exp_t e;
      logic [6:0] opcs[10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h00};
      int k;
      chk("rnd.valid", 32'(out_valid), 32'(q.size() > 0));
      chk("rnd.ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) chk_entry("rnd", q[0]);
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 3);
      instr     = $urandom();
      k         = int'($urandom_range(0, 9));
      if (k != 9) instr[6:0] = opcs[k];
      if ($urandom_range(0, 3) < 3) instr[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      pc = $urandom(); rs1_data = $urandom(); rs2_data = $urandom();
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && out_ready;
      e   = ref_dec(instr, pc, rs1_data, rs2_data);
      if (flush) q.delete();
      else begin
        if (pp)  void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      @(negedge clk);
    end

    // Reset asserted while FULL.
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h123452B7);
    @(negedge clk);
    drive(1'b1, 32'hFFB00093);
    @(negedge clk);
    chk("rst_full.is_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_full");
    rst_n = 1'b1; drive(1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
